// File: rtl/mem_latency_slave_if.sv
// Mem_ift link between the cache wrapper (master) and the backing-memory model (slave).
interface mem_latency_slave_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0]   raddr;
    logic                    ren;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic                    wen;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wmask;
    logic                    wvalid;

    modport master (
        output raddr, ren, waddr, wen, wdata, wmask,
        input  rdata, rvalid, wvalid
    );

    modport slave (
        input  raddr, ren, waddr, wen, wdata, wmask,
        output rdata, rvalid, wvalid
    );
endinterface

// File: rtl/mem_latency_slave.sv
// Fixed-latency backing memory on the slave side of the Mem_ift link.
// One read or write in flight; completion is a single-cycle rvalid/wvalid pulse
// followed by one dead cycle so a held request is not accepted twice.
// Optional feature: define MEM_BOUND_CHECK_EN to add the sticky out-of-range err output.
module mem_latency_slave #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef MEM_BOUND_CHECK_EN
    output logic                     err,
`endif
    mem_latency_slave_if.slave       bus
);
    localparam int unsigned NBytes = DATA_WIDTH / 8;
    localparam int unsigned Offs   = $clog2(NBytes);
    localparam int unsigned IdxW   = $clog2(DEPTH);
    localparam logic [7:0]  LatM1  = 8'(LATENCY - 1);

    typedef enum logic [2:0] {StIdle, StRBusy, StWBusy, StDone, StGap} state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NBytes-1:0]   wmask_q, wmask_d;
    logic                commit;
    logic [DATA_WIDTH-1:0] rdata;
    logic                rvalid, wvalid;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

`ifdef MEM_BOUND_CHECK_EN
    logic                  oob_q, oob_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] acc_addr;

    // Address of whichever request wins in IDLE; only meaningful on accept.
    assign acc_addr = bus.wen ? bus.waddr : bus.raddr;
    assign err      = err_q;
`endif

    // Next-state: accept in IDLE (write wins), count down, pulse, then one dead cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
`ifdef MEM_BOUND_CHECK_EN
        oob_d   = oob_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.wen || bus.ren) begin
                    cnt_d = LatM1;
`ifdef MEM_BOUND_CHECK_EN
                    oob_d = (acc_addr >> (Offs + IdxW)) != '0;
                    err_d = err_q | oob_d;
`endif
                end
                if (bus.wen) begin
                    wr_d    = 1'b1;
                    idx_d   = bus.waddr[Offs +: IdxW];
                    wdata_d = bus.wdata;
                    wmask_d = bus.wmask;
                    state_d = (LATENCY == 1) ? StDone : StWBusy;
                end else if (bus.ren) begin
                    wr_d    = 1'b0;
                    idx_d   = bus.raddr[Offs +: IdxW];
                    state_d = (LATENCY == 1) ? StDone : StRBusy;
                end
            end
            StRBusy, StWBusy: begin
                // Counter hits zero on entry to DONE, i.e. LATENCY cycles after accept.
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and latched request; memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
`ifdef MEM_BOUND_CHECK_EN
            oob_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
`ifdef MEM_BOUND_CHECK_EN
            oob_q   <= oob_d;
            err_q   <= err_d;
`endif
        end
    end

    // Completion pulses; everything forced idle while reset is asserted.
    always_comb begin
        rvalid = 1'b0;
        wvalid = 1'b0;
        rdata  = '0;
        commit = 1'b0;
        if (!rst && state_q == StDone) begin
            if (wr_q) begin
                wvalid = 1'b1;
                commit = 1'b1;
`ifdef MEM_BOUND_CHECK_EN
                commit = !oob_q;
`endif
            end else begin
                rvalid = 1'b1;
                rdata  = mem_q[idx_q];
`ifdef MEM_BOUND_CHECK_EN
                if (oob_q) begin
                    rdata = '1;
                end
`endif
            end
        end
    end

    // Byte-masked write commits at the end of the DONE cycle.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < int'(NBytes); i++) begin
                if (wmask_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.rdata  = rdata;
    assign bus.rvalid = rvalid;
    assign bus.wvalid = wvalid;

endmodule

// File: tb/tb_mem_latency_slave.sv
// Directed and randomized checks of mem_latency_slave against a per-entry byte model.
module tb_mem_latency_slave;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [127:0] model_mem [1024];

    always #5 clk = ~clk;

    mem_latency_slave_if #(.ADDR_WIDTH(64), .DATA_WIDTH(128)) b0 ();
    mem_latency_slave_if #(.ADDR_WIDTH(64), .DATA_WIDTH(128)) b1 ();

`ifdef MEM_BOUND_CHECK_EN
    logic err0, err1;
`endif

    mem_latency_slave #(.ADDR_WIDTH(64), .DATA_WIDTH(128), .DEPTH(1024), .LATENCY(LAT)) u_dut (
        .clk (clk),
        .rst (rst),
`ifdef MEM_BOUND_CHECK_EN
        .err (err0),
`endif
        .bus (b0.slave)
    );

    mem_latency_slave #(.ADDR_WIDTH(64), .DATA_WIDTH(128), .DEPTH(1024), .LATENCY(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
`ifdef MEM_BOUND_CHECK_EN
        .err (err1),
`endif
        .bus (b1.slave)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int entry_of(input logic [63:0] addr);
        return int'((addr >> 4) % 64'd1024);
    endfunction

    function automatic void model_write(input logic [63:0] addr, input logic [127:0] data,
                                        input logic [15:0] mask);
        int e;
        e = entry_of(addr);
        for (int b = 0; b < 16; b++) begin
            if (mask[b]) model_mem[e][8*b +: 8] = data[8*b +: 8];
        end
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at the negedge of the next IDLE cycle.
    // mode: 0 drop at pulse, 1 hold one extra cycle, 2 drop right after accept,
    //       3 scramble request inputs while busy.
    task automatic txn(input bit is_wr, input logic [63:0] addr, input logic [127:0] data,
                       input logic [15:0] mask, input int mode);
        logic [127:0] exp_rd;
        exp_rd = model_mem[entry_of(addr)];
        if (is_wr) begin
            b0.wen = 1'b1; b0.waddr = addr; b0.wdata = data; b0.wmask = mask;
        end else begin
            b0.ren = 1'b1; b0.raddr = addr;
        end
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            chk("wvalid", {127'd0, b0.wvalid}, {127'd0, is_wr && k == LAT});
            chk("rvalid", {127'd0, b0.rvalid}, {127'd0, !is_wr && k == LAT});
            if (!is_wr) chk("rdata", b0.rdata, (k == LAT) ? exp_rd : 128'd0);
            if (k == 1 && mode == 2) begin
                b0.wen = 1'b0; b0.ren = 1'b0;
            end
            if (k == 1 && mode == 3) begin
                b0.waddr = {$urandom, $urandom}; b0.raddr = {$urandom, $urandom};
                b0.wdata = {$urandom, $urandom, $urandom, $urandom};
                b0.wmask = 16'($urandom);
            end
            if ((k == LAT && mode != 1) || k == LAT + 1) begin
                b0.wen = 1'b0; b0.ren = 1'b0;
            end
        end
        if (is_wr) model_write(addr, data, mask);
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] d, pre;
        b0.wen = 0; b0.ren = 0; b0.waddr = '0; b0.raddr = '0; b0.wdata = '0; b0.wmask = '0;
        b1.wen = 0; b1.ren = 0; b1.waddr = '0; b1.raddr = '0; b1.wdata = '0; b1.wmask = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rvalid", {127'd0, b0.rvalid}, 128'd0);
        chk("rst_wvalid", {127'd0, b0.wvalid}, 128'd0);
        chk("rst_rdata", b0.rdata, 128'd0);
`ifdef MEM_BOUND_CHECK_EN
        chk("rst_err", {127'd0, err0}, 128'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Full write then read back
        txn(1'b1, 64'h40, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF, 0);
        txn(1'b0, 64'h40, '0, '0, 0);

        // Partial byte mask over a zeroed entry
        txn(1'b1, 64'h40, 128'd0, 16'hFFFF, 0);
        txn(1'b1, 64'h40, {128{1'b1}}, 16'h00FF, 0);
        chk("mask_model", model_mem[4], 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
        txn(1'b0, 64'h40, '0, '0, 0);

        // Simultaneous ren/wen to 0x80: write first, read accepted L+2 later
        d = 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF;
        b0.wen = 1; b0.waddr = 64'h80; b0.wdata = d; b0.wmask = 16'hFFFF;
        b0.ren = 1; b0.raddr = 64'h80;
        for (int k = 1; k <= 2 * LAT + 3; k++) begin
            @(negedge clk);
            chk("both_wvalid", {127'd0, b0.wvalid}, {127'd0, k == LAT});
            chk("both_rvalid", {127'd0, b0.rvalid}, {127'd0, k == 2 * LAT + 2});
            chk("both_rdata", b0.rdata, (k == 2 * LAT + 2) ? d : 128'd0);
            if (k == LAT) b0.wen = 0;
            if (k == 2 * LAT + 2) b0.ren = 0;
        end
        model_write(64'h80, d, 16'hFFFF);
        @(negedge clk);

        // Held read request: one pulse only, nothing accepted afterwards
        txn(1'b0, 64'h80, '0, '0, 1);
        for (int k = 0; k < LAT + 2; k++) begin
            chk("held_rvalid", {127'd0, b0.rvalid}, 128'd0);
            @(negedge clk);
        end

        // Reset two cycles into a write to 0x100 drops it
        pre = 128'h5555AAAA_0F0F0F0F_12345678_9ABCDEF0;
        txn(1'b1, 64'h100, pre, 16'hFFFF, 0);
        b0.wen = 1; b0.waddr = 64'h100; b0.wdata = ~pre; b0.wmask = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 3; k <= 5; k++) begin
            @(negedge clk);
            chk("rstw_wvalid", {127'd0, b0.wvalid}, 128'd0);
            chk("rstw_rvalid", {127'd0, b0.rvalid}, 128'd0);
            chk("rstw_rdata", b0.rdata, 128'd0);
        end
        rst = 1'b0; b0.wen = 0;
        @(negedge clk);
        txn(1'b0, 64'h100, '0, '0, 0);

        // LATENCY=1 instance: address wraps modulo DEPTH
        d = 128'h0BADC0DE_11111111_22222222_33333333;
        b1.wen = 1; b1.waddr = 64'h0; b1.wdata = d; b1.wmask = 16'hFFFF;
        @(negedge clk);
        chk("l1_wvalid", {127'd0, b1.wvalid}, 128'd1);
        b1.wen = 0;
        @(negedge clk);
        chk("l1_gap", {127'd0, b1.wvalid}, 128'd0);
        @(negedge clk);
        b1.ren = 1; b1.raddr = 64'h4000;
        @(negedge clk);
        chk("l1_rvalid", {127'd0, b1.rvalid}, 128'd1);
`ifdef MEM_BOUND_CHECK_EN
        chk("l1_rdata_oob", b1.rdata, {128{1'b1}});
        chk("l1_err", {127'd0, err1}, 128'd1);
`else
        chk("l1_rdata_wrap", b1.rdata, d);
`endif
        b1.ren = 0;
        @(negedge clk);
        chk("l1_gap_r", {127'd0, b1.rvalid}, 128'd0);
        @(negedge clk);

        // Randomized traffic over entries 0..7
        for (int e = 0; e < 8; e++) begin
            txn(1'b1, 64'(e * 16), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 0);
        end
        for (int n = 0; n < 24; n++) begin
            logic [63:0] a;
            a = 64'($urandom_range(7, 0) * 16 + $urandom_range(15, 0));
            txn(1'($urandom_range(1, 0)), a, {$urandom, $urandom, $urandom, $urandom},
                16'($urandom), int'($urandom_range(3, 0)));
        end
        for (int e = 0; e < 8; e++) begin
            txn(1'b0, 64'(e * 16), '0, '0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
